// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - M:SS BCD elapsed-time counter with a pausable one-second prescaler
module bcd_timer #(
  parameter int unsigned TICKS_PER_SECOND = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       count,
  output logic [3:0] seconds0,
  output logic [3:0] seconds1,
  output logic [3:0] minutes0
);

  localparam logic [31:0] PRESC_MAX = 32'(TICKS_PER_SECOND - 1);

  logic [31:0] presc_q = '0;
  logic [31:0] presc_d;
  logic [3:0]  sec0_q = '0;
  logic [3:0]  sec0_d;
  logic [3:0]  sec1_q = '0;
  logic [3:0]  sec1_d;
  logic [3:0]  min0_q = '0;
  logic [3:0]  min0_d;

  logic tick;
  logic sec0_wrap;
  logic sec1_wrap;
  logic min0_wrap;

  // Out-of-range digits compare as their wrap value, so they clear and carry.
  assign sec0_wrap = (sec0_q >= 4'd9);
  assign sec1_wrap = (sec1_q >= 4'd5);
  assign min0_wrap = (min0_q >= 4'd9);

  assign tick = count && (presc_q >= PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    sec0_d  = sec0_q;
    sec1_d  = sec1_q;
    min0_d  = min0_q;

    if (!reset) begin
      presc_d = '0;
      sec0_d  = '0;
      sec1_d  = '0;
      min0_d  = '0;
    end else if (count) begin
      presc_d = tick ? 32'd0 : presc_q + 32'd1;
      if (tick) begin
        sec0_d = sec0_wrap ? 4'd0 : sec0_q + 4'd1;
        if (sec0_wrap) begin
          sec1_d = sec1_wrap ? 4'd0 : sec1_q + 4'd1;
          if (sec1_wrap) begin
            min0_d = min0_wrap ? 4'd0 : min0_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    presc_q <= presc_d;
    sec0_q  <= sec0_d;
    sec1_q  <= sec1_d;
    min0_q  <= min0_d;
  end

  assign seconds0 = sec0_q;
  assign seconds1 = sec1_q;
  assign minutes0 = min0_q;

endmodule

// File: tb/tb_bcd_timer.sv
// tb/tb_bcd_timer.sv - bench for bcd_timer at TICKS_PER_SECOND=4 and =1
module tb_bcd_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, cnt_a = 1'b0;
  logic rst_b = 1'b0, cnt_b = 1'b0;
  logic [3:0] a_s0, a_s1, a_m0;
  logic [3:0] b_s0, b_s1, b_m0;

  int total = 0;
  int bad = 0;
  int e_a = 0;
  int e_b = 0;
  logic done_b = 1'b0;
  logic mon_on = 1'b0;

  bcd_timer #(.TICKS_PER_SECOND(4)) dut_a (
    .clk(clk), .reset(rst_a), .count(cnt_a),
    .seconds0(a_s0), .seconds1(a_s1), .minutes0(a_m0)
  );

  bcd_timer #(.TICKS_PER_SECOND(1)) dut_b (
    .clk(clk), .reset(rst_b), .count(cnt_b),
    .seconds0(b_s0), .seconds1(b_s1), .minutes0(b_m0)
  );

  // Display is whole seconds elapsed over enabled edges since reset, modulo ten minutes.
  function automatic logic [11:0] disp(input int e, input int t);
    int s;
    s = (e / t) % 600;
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (m:s1:s0)", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (!rst_a) e_a <= 0;
    else if (cnt_a) e_a <= e_a + 1;
    if (!rst_b) e_b <= 0;
    else if (cnt_b) e_b <= e_b + 1;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("model_a", {a_m0, a_s1, a_s0}, disp(e_a, 4));
      check("model_b", {b_m0, b_s1, b_s0}, disp(e_b, 1));
    end
  end

  initial begin
    #1;
    check("powerup_b", {b_m0, b_s1, b_s0}, 12'h000);
    step(2);
    rst_b = 1'b1; cnt_b = 1'b1;
    step(1);   check("t1_first", {b_m0, b_s1, b_s0}, 12'h001);
    step(58);  check("t1_59s", {b_m0, b_s1, b_s0}, 12'h059);
    step(1);   check("t1_minute", {b_m0, b_s1, b_s0}, 12'h100);
    cnt_b = 1'b0;
    step(10);  check("t1_pause", {b_m0, b_s1, b_s0}, 12'h100);
    cnt_b = 1'b1;
    step(539); check("t1_959", {b_m0, b_s1, b_s0}, 12'h959);
    step(1);   check("t1_wrap", {b_m0, b_s1, b_s0}, 12'h000);
    done_b = 1'b1;
  end

  initial begin
    #1;
    check("powerup_a", {a_m0, a_s1, a_s0}, 12'h000);
    mon_on = 1'b1;
    step(2);
    rst_a = 1'b1; cnt_a = 1'b1;
    step(4);    check("run_1s", {a_m0, a_s1, a_s0}, 12'h001);
    step(36);   check("run_10s", {a_m0, a_s1, a_s0}, 12'h010);
    step(196);  check("run_59s", {a_m0, a_s1, a_s0}, 12'h059);
    step(3);    check("pre_minute", {a_m0, a_s1, a_s0}, 12'h059);
    step(1);    check("minute", {a_m0, a_s1, a_s0}, 12'h100);
    step(2156); check("run_959", {a_m0, a_s1, a_s0}, 12'h959);
    step(4);    check("full_wrap", {a_m0, a_s1, a_s0}, 12'h000);

    rst_a = 1'b0; step(1); rst_a = 1'b1;
    step(6);    check("pause_pre", {a_m0, a_s1, a_s0}, 12'h001);
    cnt_a = 1'b0;
    step(100);  check("pause_hold", {a_m0, a_s1, a_s0}, 12'h001);
    cnt_a = 1'b1;
    step(1);    check("resume_1", {a_m0, a_s1, a_s0}, 12'h001);
    step(1);    check("resume_2", {a_m0, a_s1, a_s0}, 12'h002);

    rst_a = 1'b0; step(1); rst_a = 1'b1;
    step(828);  check("at_327", {a_m0, a_s1, a_s0}, 12'h327);
    step(3);    check("tick_due", {a_m0, a_s1, a_s0}, 12'h327);
    rst_a = 1'b0;
    step(1);    check("reset_prio", {a_m0, a_s1, a_s0}, 12'h000);
    rst_a = 1'b1;
    step(3);    check("post_rst_3", {a_m0, a_s1, a_s0}, 12'h000);
    step(1);    check("post_rst_4", {a_m0, a_s1, a_s0}, 12'h001);

    step(3);
    cnt_a = 1'b0;
    step(1);    check("pause_tick_edge", {a_m0, a_s1, a_s0}, 12'h001);
    step(5);    check("pause_tick_hold", {a_m0, a_s1, a_s0}, 12'h001);
    cnt_a = 1'b1;
    step(1);    check("tick_on_resume", {a_m0, a_s1, a_s0}, 12'h002);
    step(3);    check("after_resume_3", {a_m0, a_s1, a_s0}, 12'h002);
    step(1);    check("after_resume_4", {a_m0, a_s1, a_s0}, 12'h003);

    total++;
    if (!done_b) begin
      bad++;
      $display("FAIL t1_sequence: got done=%0b expected done=1", done_b);
    end
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
